// File: rtl/dsp_pipe_reg.sv
// Parametrised DSP48A1 operand/result delay line with runtime-selected tap (0 = bypass).
// Optional occupancy counter port 'occ' is built when DSP_PIPE_OCC_EN is defined.
module dsp_pipe_reg #(
   parameter  int WIDTH = 18,
   parameter  int DEPTH = 4,
   localparam int LAT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [LAT_W-1:0] lat_sel,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             lat_err
`ifdef DSP_PIPE_OCC_EN
  ,output logic [LAT_W-1:0] occ
`endif
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             lat_err_q, lat_err_d;
   logic             lat_over;
   logic             lat_chg;

   always_comb begin
      lat_over  = (32'(lat_sel) > 32'(DEPTH));
      lat_d     = lat_over ? LAT_W'(DEPTH) : lat_sel;
      lat_chg   = (lat_d != lat_q);
      lat_err_d = lat_err_q | lat_over;

      data_d = data_q;
      vld_d  = vld_q;
      if (ce) begin
         data_d[0] = in_data;
         vld_d[0]  = in_valid;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
      // A tap move drops everything behind stage 0 so no stale sample reaches the new tap.
      if (lat_chg) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i] = 1'b0;
         end
         if (!ce) begin
            vld_d[0] = 1'b0;
         end
      end
   end

   always_comb begin
      out_valid = in_valid;
      out_data  = in_data;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         if (32'(lat_q) == k) begin
            out_valid = vld_q[k-1];
            out_data  = data_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         vld_q     <= '0;
         lat_q     <= '0;
         lat_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         vld_q     <= vld_d;
         lat_q     <= lat_d;
         lat_err_q <= lat_err_d;
      end
   end

   assign lat_err = lat_err_q;

`ifdef DSP_PIPE_OCC_EN
   logic [LAT_W-1:0] occ_q, occ_d;

   // Counting the next-state valid bits below the next tap covers both the
   // incremental enter/leave update and the recount after a latency change.
   always_comb begin
      occ_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (k < 32'(lat_d)) begin
            occ_d = occ_d + LAT_W'(vld_d[k]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Scoreboard bench for dsp_pipe_reg: expected samples queued at drive time with their due cycle.
module tb_dsp_pipe_reg;

   localparam int unsigned WIDTH = 18;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ce = 1'b1;
   logic [LAT_W-1:0] lat_sel = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             lat_err;
`ifdef DSP_PIPE_OCC_EN
   logic [LAT_W-1:0] occ;
`endif

   dsp_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .lat_sel  (lat_sel),
      .in_valid (in_valid),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .lat_err  (lat_err)
`ifdef DSP_PIPE_OCC_EN
     ,.occ      (occ)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      int unsigned      due;
   } sb_t;

   sb_t         q[$];
   int unsigned ccnt = 0;
   int unsigned m_lat = 0;
   logic        m_err = 1'b0;
   logic        mon_en = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic        exp_v;
   int unsigned exp_occ;

   // Monitor: the queue front is the sample the DUT must be presenting this cycle.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         exp_v = (q.size() > 0) && (q[0].due == ccnt);
         checks++;
         if (out_valid !== exp_v) begin
            failures++;
            $display("FAIL sb_valid cyc=%0d got=%b exp=%b", ccnt, out_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (out_data !== q[0].d) begin
               failures++;
               $display("FAIL sb_data cyc=%0d got=%h exp=%h", ccnt, out_data, q[0].d);
            end
         end
         checks++;
         if (lat_err !== m_err) begin
            failures++;
            $display("FAIL sb_lat_err cyc=%0d got=%b exp=%b", ccnt, lat_err, m_err);
         end
`ifdef DSP_PIPE_OCC_EN
         exp_occ = (m_lat == 0) ? 0 : q.size();
         checks++;
         if (32'(occ) !== exp_occ) begin
            failures++;
            $display("FAIL sb_occ cyc=%0d got=%0d exp=%0d", ccnt, occ, exp_occ);
         end
`endif
      end
   end

   // Apply inputs for one cycle and wait for the sampling point.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c,
                        input logic [LAT_W-1:0] ls);
      in_valid = v;
      in_data  = d;
      ce       = c;
      lat_sel  = ls;
      if (v && m_lat == 0) q.push_back('{d, ccnt});
      @(negedge clk);
   endtask

   // Clock edge bookkeeping: retire, flush on tap change, enqueue captured sample.
   task automatic advance();
      int unsigned nl;
      nl = (32'(lat_sel) > DEPTH) ? DEPTH : 32'(lat_sel);
      @(posedge clk);
      if (q.size() > 0 && q[0].due == ccnt && (ce || m_lat == 0)) void'(q.pop_front());
      if (nl != m_lat) q.delete();
      if (in_valid && ce && nl != 0) q.push_back('{in_data, ccnt + nl});
      if (32'(lat_sel) > DEPTH) m_err = 1'b1;
      m_lat = nl;
      if (ce) ccnt++;
      #1;
   endtask

   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic c,
                        input logic [LAT_W-1:0] ls);
      drive(v, d, c, ls);
      advance();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if (out_valid !== 1'b0 || lat_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got v=%b err=%b exp v=0 err=0", out_valid, lat_err);
      end
`ifdef DSP_PIPE_OCC_EN
      checks++;
      if (occ !== '0) begin
         failures++;
         $display("FAIL reset_occ got=%0d exp=0", occ);
      end
`endif
      in_valid = 1'b1;
      in_data  = 18'h155;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h155) begin
         failures++;
         $display("FAIL bypass_in_reset got v=%b d=%h exp v=1 d=155", out_valid, out_data);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      cycle(1'b1, 18'h155, 1'b1, 3'd0);
      cycle(1'b1, 18'h0AA, 1'b1, 3'd0);
   endtask

   task automatic test_latency3();
      cycle(1'b0, '0, 1'b1, 3'd3);
      cycle(1'b1, 18'd1, 1'b1, 3'd3);
      cycle(1'b1, 18'd2, 1'b1, 3'd3);
      drive(1'b1, 18'd3, 1'b1, 3'd3);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat3_early got v=%b exp v=0", out_valid);
      end
      advance();
      drive(1'b1, 18'd4, 1'b1, 3'd3);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'd1) begin
         failures++;
         $display("FAIL lat3_first got v=%b d=%h exp v=1 d=1", out_valid, out_data);
      end
`ifdef DSP_PIPE_OCC_EN
      checks++;
      if (occ !== 3'd3) begin
         failures++;
         $display("FAIL lat3_occ got=%0d exp=3", occ);
      end
`endif
      advance();
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 3'd3);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL lat3_drain got pending=%0d exp 0", q.size());
      end
   endtask

   task automatic test_ce_hold();
      cycle(1'b0, '0, 1'b1, 3'd2);
      cycle(1'b1, 18'h10, 1'b1, 3'd2);
      cycle(1'b1, 18'h11, 1'b1, 3'd2);
      cycle(1'b1, 18'h12, 1'b1, 3'd2);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 18'h3FFFF, 1'b0, 3'd2);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 18'h11) begin
            failures++;
            $display("FAIL ce_freeze i=%0d got v=%b d=%h exp v=1 d=11", i, out_valid, out_data);
         end
         advance();
      end
      cycle(1'b1, 18'h13, 1'b1, 3'd2);
      cycle(1'b1, 18'h14, 1'b1, 3'd2);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 3'd2);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL ce_drain got pending=%0d exp 0", q.size());
      end
   endtask

   task automatic test_lat_change();
      logic [WIDTH-1:0] d;
      cycle(1'b0, '0, 1'b1, 3'd4);
      for (int i = 0; i < 5; i++) begin
         d = 18'h20 + 18'(i);
         cycle(1'b1, d, 1'b1, 3'd4);
      end
      drive(1'b1, 18'h25, 1'b1, 3'd1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h21) begin
         failures++;
         $display("FAIL chg_last_old got v=%b d=%h exp v=1 d=21", out_valid, out_data);
      end
      advance();
      drive(1'b1, 18'h26, 1'b1, 3'd1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h25) begin
         failures++;
         $display("FAIL chg_new_tap got v=%b d=%h exp v=1 d=25", out_valid, out_data);
      end
`ifdef DSP_PIPE_OCC_EN
      checks++;
      if (occ !== 3'd1) begin
         failures++;
         $display("FAIL chg_occ got=%0d exp=1", occ);
      end
`endif
      advance();
      cycle(1'b1, 18'h27, 1'b1, 3'd1);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 3'd1);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL chg_drain got pending=%0d exp 0", q.size());
      end
   endtask

   task automatic test_lat_err();
      cycle(1'b0, '0, 1'b1, 3'd7);
      checks++;
      if (lat_err !== 1'b1) begin
         failures++;
         $display("FAIL lat_err_set got=%b exp=1", lat_err);
      end
      for (int i = 0; i < 3; i++) cycle(1'b1, 18'h30 + 18'(i), 1'b1, 3'd7);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 3'd7);
      cycle(1'b0, '0, 1'b1, 3'd2);
      cycle(1'b1, 18'h33, 1'b1, 3'd2);
      cycle(1'b1, 18'h34, 1'b1, 3'd2);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 3'd2);
      checks++;
      if (lat_err !== 1'b1 || q.size() != 0) begin
         failures++;
         $display("FAIL lat_err_sticky got err=%b pending=%0d exp err=1 pending=0", lat_err, q.size());
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b0, '0, 1'b1, 3'd7);
      for (int i = 0; i < 4; i++) cycle(1'b1, 18'h40 + 18'(i), 1'b1, 3'd7);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h40 || lat_err !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst got v=%b d=%h err=%b exp v=1 d=40 err=1", out_valid, out_data, lat_err);
      end
      mon_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || lat_err !== 1'b0) begin
         failures++;
         $display("FAIL async_rst got v=%b err=%b exp v=0 err=0", out_valid, lat_err);
      end
`ifdef DSP_PIPE_OCC_EN
      checks++;
      if (occ !== '0) begin
         failures++;
         $display("FAIL async_rst_occ got=%0d exp=0", occ);
      end
`endif
      q.delete();
      m_lat   = 0;
      m_err   = 1'b0;
      lat_sel = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      cycle(1'b1, 18'h2A, 1'b1, 3'd0);
      cycle(1'b0, '0, 1'b1, 3'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency3();
      test_ce_hold();
      test_lat_change();
      test_lat_err();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
